// File: rtl/regcopy_arbiter_if.sv
// Bus between the upstream loaders (master) and the register-copy arbiter (slave).
// Carries the request/data handshake plus the register bank and clear-timing outputs.
interface regcopy_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [2:0]       req;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [2:0]       gnt;
  logic [WIDTH-1:0] Q1;
  logic [WIDTH-1:0] Q2;
  logic [WIDTH-1:0] Q3;
  logic             clr;
  logic [7:0]       cnt;

  modport master (
    output req, A, B, C,
    input  gnt, Q1, Q2, Q3, clr, cnt
  );

  modport slave (
    input  req, A, B, C,
    output gnt, Q1, Q2, Q3, clr, cnt
  );
endinterface

// File: rtl/regcopy_arbiter.sv
// Round-robin arbiter sharing one write port of a 3-entry register bank,
// with a free-running period counter that clears a masked subset of registers.
module regcopy_arbiter #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CLR_PERIOD = 12,
  parameter logic [2:0]  CLR_MASK   = 3'b110
) (
  input logic             clk,
  input logic             rst,
  regcopy_arbiter_if.slave bus
);

  localparam bit         ClrEn   = (CLR_PERIOD != 0);
  localparam logic [7:0] LastCnt = 8'((CLR_PERIOD == 0) ? 0 : CLR_PERIOD - 1);

  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             clr_q, clr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q [3];
  logic [WIDTH-1:0] q_d [3];
  logic [WIDTH-1:0] data [3];
  logic [2:0]       elig;
  logic [1:0]       idx0, idx1, idx2;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign data[0] = bus.A;
  assign data[1] = bus.B;
  assign data[2] = bus.C;

  // A requester granted this cycle sits out the next arbitration.
  assign elig = bus.req & ~gnt_q;
  assign idx0 = ptr_q;
  assign idx1 = inc3(idx0);
  assign idx2 = inc3(idx1);

  always_comb begin
    gnt_d = 3'b000;
    ptr_d = ptr_q;
    if (elig[idx0]) begin
      gnt_d[idx0] = 1'b1;
      ptr_d       = idx1;
    end else if (elig[idx1]) begin
      gnt_d[idx1] = 1'b1;
      ptr_d       = idx2;
    end else if (elig[idx2]) begin
      gnt_d[idx2] = 1'b1;
      ptr_d       = idx0;
    end
  end

  always_comb begin
    cnt_d = 8'd0;
    clr_d = 1'b0;
    if (ClrEn) begin
      cnt_d = (cnt_q == LastCnt) ? 8'd0 : cnt_q + 8'd1;
      clr_d = (cnt_q == LastCnt);
    end
  end

  // A write in the same cycle as a clear takes priority.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      q_d[i] = q_q[i];
      if (gnt_q[i]) begin
        q_d[i] = data[i];
      end else if (clr_q && CLR_MASK[i]) begin
        q_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= 3'b000;
      ptr_q <= 2'd0;
      clr_q <= 1'b0;
      cnt_q <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      clr_q <= clr_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < 3; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.Q1  = q_q[0];
  assign bus.Q2  = q_q[1];
  assign bus.Q3  = q_q[2];
  assign bus.clr = clr_q;
  assign bus.cnt = cnt_q;

endmodule
